// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer
//   Walks one fully-connected layer pass node by node. For each output
//   node it fetches the weight row, issues one PE operation, waits a
//   fixed PE latency, captures the reduced result and offers it
//   downstream with a valid/ready handshake. A pass ends with a
//   one-cycle done pulse.
//
// Ports
//   i_clk          rising-edge clock
//   i_reset        asynchronous active-high reset
//   i_start        one-cycle request to begin a pass (honoured in IDLE only)
//   i_abort        synchronous cancel of a pass in progress
//   o_w_rd_en      weight-row memory read strobe
//   o_w_addr       weight-row address (always equals the node index)
//   o_pe_clear     clears the PE accumulators
//   o_pe_valid     PE operands are valid this cycle
//   i_result_in    reduced PE result, valid PE_LATENCY cycles after o_pe_valid
//   o_out_valid    o_out_data / o_out_index hold a result
//   i_out_ready    downstream accepts the result
//   o_out_data     captured node result
//   o_out_index    node index of o_out_data
//   o_busy         high whenever a pass is in progress
//   o_done         one-cycle pulse when a pass completes normally
module fc_layer_sequencer #(
   parameter int DATA_WIDTH   = 16,
   parameter int INPUT_NODES  = 120,
   parameter int OUTPUT_NODES = 1200,
   parameter int PE_LATENCY   = 4,
   localparam int IDX_W       = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_abort,
   output logic                  o_w_rd_en,
   output logic [IDX_W-1:0]      o_w_addr,
   output logic                  o_pe_clear,
   output logic                  o_pe_valid,
   input  logic [DATA_WIDTH-1:0] i_result_in,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic [IDX_W-1:0]      o_out_index,
   output logic                  o_busy,
   output logic                  o_done
);

   // Elaboration-time guards on the parameter ranges.
   if (PE_LATENCY < 1) begin : g_bad_latency
      $error("fc_layer_sequencer: PE_LATENCY must be >= 1");
   end
   if (INPUT_NODES < 1) begin : g_bad_inputs
      $error("fc_layer_sequencer: INPUT_NODES must be >= 1");
   end

   localparam int                CNT_W     = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(PE_LATENCY - 1);
   localparam logic [IDX_W-1:0]  LAST_NODE = IDX_W'(OUTPUT_NODES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_EMIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [IDX_W-1:0]      r_node;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [IDX_W-1:0]      r_out_index;

   logic w_handshake;
   logic w_last_node;
   logic w_abort_hit;

   assign w_handshake = (r_state == S_EMIT) && i_out_ready;
   assign w_last_node = (r_node == LAST_NODE);
   // abort only cancels a pass; in IDLE it is ignored so start always wins.
   assign w_abort_hit = i_abort && (r_state != S_IDLE);

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_next = S_FETCH;
         S_FETCH: w_state_next = S_ISSUE;
         S_ISSUE: w_state_next = S_WAIT;
         S_WAIT:  if (r_cnt == '0) w_state_next = S_EMIT;
         S_EMIT:  if (w_handshake) w_state_next = w_last_node ? S_DONE : S_FETCH;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
      if (w_abort_hit) begin
         w_state_next = S_IDLE;
      end
   end

   // Node index, PE wait counter and captured result
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_node      <= '0;
         r_cnt       <= '0;
         r_out_data  <= '0;
         r_out_index <= '0;
      end else if (w_abort_hit) begin
         r_node <= '0;
         r_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) r_node <= '0;
            end
            // Counter runs PE_LATENCY-1 down to 0, so WAIT lasts PE_LATENCY
            // cycles and the capture lands on the cycle result_in is valid.
            S_ISSUE: r_cnt <= CNT_LOAD;
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_out_data  <= i_result_in;
                  r_out_index <= r_node;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_EMIT: begin
               // The last node never increments, so the index cannot wrap.
               if (w_handshake && !w_last_node) r_node <= r_node + IDX_W'(1);
            end
            S_DONE:  r_node <= '0;
            default: ;
         endcase
      end
   end

   // Outputs are pure state decodes or registers; no path from inputs.
   assign o_w_rd_en   = (r_state == S_FETCH);
   assign o_w_addr    = r_node;
   assign o_pe_valid  = (r_state == S_ISSUE);
   assign o_pe_clear  = (r_state == S_ISSUE);
   assign o_out_valid = (r_state == S_EMIT);
   assign o_out_data  = r_out_data;
   assign o_out_index = r_out_index;
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer
//   Small-layer instance (4 nodes, latency 4) driven by a scenario table,
//   random traffic, and an asynchronous reset sequence, all checked each
//   cycle against a position-within-node reference model. A second
//   instance (1200 nodes, latency 1) checks full-pass timing.
module tb_fc_layer_sequencer;
   localparam int DW  = 16;
   localparam int N   = 4;
   localparam int L   = 4;
   localparam int IW  = 2;
   localparam int N2  = 1200;
   localparam int IW2 = 11;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, abort, ready;
   logic [DW-1:0] result;
   logic          w_rd_en, pe_clear, pe_valid, out_valid, busy, done;
   logic [IW-1:0] w_addr, out_index;
   logic [DW-1:0] out_data;

   logic           start2, abort2, ready2;
   logic [DW-1:0]  result2;
   logic           w_rd_en2, pe_clear2, pe_valid2, out_valid2, busy2, done2;
   logic [IW2-1:0] w_addr2, out_index2;
   logic [DW-1:0]  out_data2;

   always #5 clk = ~clk;

   fc_layer_sequencer #(.DATA_WIDTH(DW), .INPUT_NODES(8), .OUTPUT_NODES(N), .PE_LATENCY(L)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
      .o_w_rd_en(w_rd_en), .o_w_addr(w_addr), .o_pe_clear(pe_clear), .o_pe_valid(pe_valid),
      .i_result_in(result), .o_out_valid(out_valid), .i_out_ready(ready),
      .o_out_data(out_data), .o_out_index(out_index), .o_busy(busy), .o_done(done)
   );

   fc_layer_sequencer #(.DATA_WIDTH(DW), .OUTPUT_NODES(N2), .PE_LATENCY(1)) dut2 (
      .i_clk(clk), .i_reset(rst), .i_start(start2), .i_abort(abort2),
      .o_w_rd_en(w_rd_en2), .o_w_addr(w_addr2), .o_pe_clear(pe_clear2), .o_pe_valid(pe_valid2),
      .i_result_in(result2), .o_out_valid(out_valid2), .i_out_ready(ready2),
      .o_out_data(out_data2), .o_out_index(out_index2), .o_busy(busy2), .o_done(done2)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: m_pos is the cycle position inside the current node
   // (0 fetch, 1 issue, 2..L+1 waiting, L+2 offering the result).
   int m_active, m_done, m_node, m_pos, m_data, m_index;

   int n_xfer, n_done, n_busy, data_sum, cyc, first_ov;

   typedef struct {
      int stall_node;
      int stall_len;
      int abort_node;
      int start_node;
      int exp_xfer;
      int exp_done;
      int exp_busy;
      int exp_sum;
   } scn_t;
   scn_t scn [4];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_done = 0; m_node = 0; m_pos = 0; m_data = 0; m_index = 0;
   endtask

   task automatic model_step(input bit s, input bit a, input bit r, input int res);
      if (m_done != 0) begin
         m_done = 0;
         m_node = 0;
      end else if (m_active == 0) begin
         if (s) begin
            m_active = 1; m_pos = 0; m_node = 0;
         end
      end else if (a) begin
         m_active = 0; m_node = 0; m_pos = 0;
      end else if (m_pos < L + 2) begin
         if (m_pos == L + 1) begin
            m_data = res; m_index = m_node;
         end
         m_pos++;
      end else if (r) begin
         if (m_node == N - 1) begin
            m_active = 0; m_done = 1;
         end else begin
            m_node++;
         end
         m_pos = 0;
      end
   endtask

   task automatic check_outputs();
      check("busy",      int'(busy),      (m_active != 0 || m_done != 0) ? 1 : 0);
      check("done",      int'(done),      m_done);
      check("w_rd_en",   int'(w_rd_en),   (m_active != 0 && m_pos == 0) ? 1 : 0);
      check("pe_valid",  int'(pe_valid),  (m_active != 0 && m_pos == 1) ? 1 : 0);
      check("pe_clear",  int'(pe_clear),  (m_active != 0 && m_pos == 1) ? 1 : 0);
      check("out_valid", int'(out_valid), (m_active != 0 && m_pos == L + 2) ? 1 : 0);
      check("w_addr",    int'(w_addr),    m_node);
      check("out_index", int'(out_index), m_index);
      check("out_data",  int'(out_data),  m_data);
   endtask

   // One clock: check at the falling edge, then drive the next inputs.
   task automatic cycle(input bit s, input bit a, input bit r, input int res);
      @(negedge clk);
      cyc++;
      check_outputs();
      if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
      if (out_valid === 1'b1 && r) begin
         n_xfer++;
         data_sum += int'(out_data);
         $display("xfer index=%0d data=%0d", out_index, out_data);
      end
      if (busy === 1'b1) n_busy++;
      if (done === 1'b1) n_done++;
      start = s; abort = a; ready = r; result = DW'(res);
      model_step(s, a, r, res);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},      int'(busy),      0);
      check({tag, "_done"},      int'(done),      0);
      check({tag, "_w_rd_en"},   int'(w_rd_en),   0);
      check({tag, "_pe_valid"},  int'(pe_valid),  0);
      check({tag, "_pe_clear"},  int'(pe_clear),  0);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_out_data"},  int'(out_data),  0);
      check({tag, "_out_index"}, int'(out_index), 0);
      check({tag, "_w_addr"},    int'(w_addr),    0);
   endtask

   initial begin
      int guard, stall_ctr, start_cyc;
      bit s, a, r;

      scn[0] = '{-1,  0, -1, -1, 4, 1, 29, 18};  // plain pass, result = node*3
      scn[1] = '{ 1, 10, -1, -1, 4, 1, 39, 18};  // 10-cycle stall at node 1
      scn[2] = '{-1,  0,  2, -1, 2, 0, 18,  3};  // abort while waiting on node 2
      scn[3] = '{-1,  0, -1,  1, 4, 1, 29, 18};  // start pulsed mid-pass

      rst = 1'b1; start = 0; abort = 0; ready = 0; result = '0;
      start2 = 0; abort2 = 0; ready2 = 1'b1; result2 = 16'h1234;
      cyc = 0; first_ov = -1;
      model_reset();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Table-driven scenarios
      for (int i = 0; i < 4; i++) begin
         n_xfer = 0; n_done = 0; n_busy = 0; data_sum = 0; stall_ctr = 0; first_ov = -1;
         cycle(1, 0, 1, 0);
         start_cyc = cyc;
         guard = 0;
         while ((m_active != 0 || m_done != 0) && guard < 300) begin
            s = (m_active != 0 && m_node == scn[i].start_node && m_pos == 1);
            a = (m_active != 0 && m_node == scn[i].abort_node && m_pos == 3);
            r = 1'b1;
            if (m_active != 0 && m_pos == L + 2 && m_node == scn[i].stall_node &&
                stall_ctr < scn[i].stall_len) begin
               r = 1'b0;
               stall_ctr++;
            end
            cycle(s, a, r, m_node * 3);
            guard++;
         end
         cycle(0, 0, 1, 0);
         check("scn_bound",     (guard < 300) ? 1 : 0, 1);
         check("scn_xfers",     n_xfer,   scn[i].exp_xfer);
         check("scn_done",      n_done,   scn[i].exp_done);
         check("scn_busy_cyc",  n_busy,   scn[i].exp_busy);
         check("scn_data_sum",  data_sum, scn[i].exp_sum);
         check("scn_first_ov",  first_ov - start_cyc, L + 3);
      end

      // Randomized traffic against the model
      for (int k = 0; k < 1500; k++) begin
         cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
               $urandom_range(0, 1) == 1, int'($urandom_range(0, 65535)));
      end

      // Asynchronous reset while a result is being offered
      cycle(0, 1, 0, 0);                 // abort any pass in flight
      cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
      guard = 0;
      while (!(m_active != 0 && m_pos == L + 2) && guard < 50) begin
         cycle(0, 0, 0, int'($urandom_range(1, 65535)));
         guard++;
      end
      cycle(0, 0, 0, 0);
      check("emit_bound", (guard < 50) ? 1 : 0, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) cycle(0, 0, 1, 0);
      n_xfer = 0;
      cycle(1, 0, 1, 0);
      guard = 0;
      while ((m_active != 0 || m_done != 0) && guard < 100) begin
         cycle(0, 0, 1, 100 + m_node);
         guard++;
      end
      cycle(0, 0, 1, 0);
      check("post_rst_xfers", n_xfer, N);

      // Full-size pass with PE_LATENCY=1
      begin
         int nb, nov, nd, first_it, second_it, last_idx, last_data;
         nb = 0; nov = 0; nd = 0; first_it = -1; second_it = -1; last_idx = -1; last_data = -1;
         @(negedge clk);
         start2 = 1'b1;
         @(negedge clk);
         start2 = 1'b0;
         for (int it = 0; it < 6000; it++) begin
            if (busy2 === 1'b1) nb++;
            if (done2 === 1'b1) nd++;
            if (out_valid2 === 1'b1) begin
               nov++;
               if (first_it < 0) first_it = it;
               else if (second_it < 0) second_it = it;
               last_idx = int'(out_index2);
               last_data = int'(out_data2);
            end
            if (busy2 !== 1'b1 && nb > 0) break;
            @(negedge clk);
         end
         check("big_busy_cyc",  nb, N2 * 4 + 1);
         check("big_out_valid", nov, N2);
         check("big_done",      nd, 1);
         check("big_first_ov",  first_it + 1, 4);
         check("big_period",    second_it - first_it, 4);
         check("big_last_idx",  last_idx, N2 - 1);
         check("big_last_data", last_data, 32'h1234);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
